// File: rtl/frog_move_input_if.sv
// rtl/frog_move_input_if.sv - move request bus between the input conditioner and the game core
interface frog_move_input_if;
    logic       move_valid;
    logic [1:0] move_dir;
    logic [3:0] sw_stable;

    modport master (output move_valid, output move_dir, output sw_stable);
    modport slave  (input  move_valid, input  move_dir, input  sw_stable);
endinterface

// File: rtl/frog_move_input.sv
// rtl/frog_move_input.sv - button sync/debounce and press + auto-repeat move request generator
module frog_move_input #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 24
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                SW1,
    input  logic                SW2,
    input  logic                SW3,
    input  logic                SW4,
    frog_move_input_if.master   mv
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    logic [3:0]       sw_raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       stable;
    logic [CNT_W-1:0] db_cnt [4];
    logic [1:0]       sel;
    logic             any_pressed;
    state_t           state;
    logic [CNT_W-1:0] timer;
    logic             valid_q;
    logic [1:0]       dir_q;

    assign sw_raw = {SW4, SW3, SW2, SW1};

    // Two-flop synchroniser; raw buttons are used nowhere else.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Per-button debounce: a new level is accepted only after it has differed
    // from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stable <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Lowest-index pressed button wins: Up > Down > Left > Right.
    always_comb begin
        sel         = 2'd3;
        any_pressed = |stable;
        if (stable[0])      sel = 2'd0;
        else if (stable[1]) sel = 2'd1;
        else if (stable[2]) sel = 2'd2;
    end

    // Press/hold/repeat FSM; dir_q doubles as the latched button while held.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            timer   <= '0;
            valid_q <= 1'b0;
            dir_q   <= 2'd0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_pressed) begin
                        valid_q <= 1'b1;
                        dir_q   <= sel;
                        timer   <= '0;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stable[dir_q]) begin
                        state <= IDLE;
                    end else if (timer == RD_LAST) begin
                        valid_q <= 1'b1;
                        timer   <= '0;
                        state   <= REPEAT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!stable[dir_q]) begin
                        state <= IDLE;
                    end else if (timer == RP_LAST) begin
                        valid_q <= 1'b1;
                        timer   <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mv.move_valid = valid_q;
    assign mv.move_dir   = dir_q;
    assign mv.sw_stable  = stable;

endmodule

// File: tb/tb_frog_move_input.sv
// tb/tb_frog_move_input.sv - directed and soak bench for frog_move_input
module tb_frog_move_input;

    logic CLK;
    logic RST;
    logic SW1, SW2, SW3, SW4;

    frog_move_input_if mv();

    frog_move_input #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5),
        .CNT_W          (24)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .SW1(SW1),
        .SW2(SW2),
        .SW3(SW3),
        .SW4(SW4),
        .mv (mv.master)
    );

    typedef struct {
        logic [3:0] sw;
        logic       valid;
        logic [1:0] dir;
        logic [3:0] stable;
    } vec_t;

    int total = 0;
    int bad   = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_sw(input logic [3:0] v);
        {SW4, SW3, SW2, SW1} = v;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Leaves the bench just after an edge with RST just released; that edge is cycle 0.
    task automatic do_reset();
        RST = 1'b1;
        set_sw(4'b0000);
        tick();
        tick();
        RST = 1'b0;
    endtask

    vec_t tbl [46];

    initial begin
        logic       prev_valid;
        logic [3:0] prev_stable;
        logic [3:0] tgt;
        logic [3:0] raw;
        logic       exp_v;

        // Test 1 (entries 0..19): SW1 high cycles 0..7.
        // Test 2 (entries 20..45): SW2 toggling every 2 cycles, then low.
        for (int i = 0; i < 46; i++) begin
            tbl[i].sw     = 4'b0000;
            tbl[i].valid  = 1'b0;
            tbl[i].dir    = 2'b00;
            tbl[i].stable = 4'b0000;
        end
        for (int i = 0; i <= 7; i++)  tbl[i].sw = 4'b0001;
        for (int i = 6; i <= 13; i++) tbl[i].stable = 4'b0001;
        tbl[7].valid = 1'b1;
        for (int i = 20; i < 40; i++) tbl[i].sw = (((i - 20) / 2) % 2 == 0) ? 4'b0010 : 4'b0000;

        do_reset();
        for (int i = 0; i < 46; i++) begin
            check($sformatf("vec%0d {valid,dir,stable}", i),
                  {25'd0, mv.move_valid, mv.move_dir, mv.sw_stable},
                  {25'd0, tbl[i].valid, tbl[i].dir, tbl[i].stable});
            set_sw(tbl[i].sw);
            tick();
        end

        // Test 3: SW4 held cycles 0..59 -> strobes at 7, then 17 + 5n up to 62.
        do_reset();
        set_sw(4'b1000);
        for (int k = 1; k <= 80; k++) begin
            tick();
            exp_v = (k == 7) || (k >= 17 && k <= 62 && (k - 17) % 5 == 0);
            check($sformatf("t3 valid c%0d", k), {31'd0, mv.move_valid}, {31'd0, exp_v});
            if (k >= 7) check($sformatf("t3 dir c%0d", k), {30'd0, mv.move_dir}, 32'd3);
            if (k == 60) set_sw(4'b0000);
        end

        // Test 4: SW1+SW3 together, SW1 dropped at cycle 10 -> strobes 7 (Up) and 18 (Left).
        do_reset();
        set_sw(4'b0101);
        for (int k = 1; k <= 25; k++) begin
            tick();
            exp_v = (k == 7) || (k == 18);
            check($sformatf("t4 valid c%0d", k), {31'd0, mv.move_valid}, {31'd0, exp_v});
            if (k == 7)  check("t4 dir first",  {30'd0, mv.move_dir}, 32'd0);
            if (k == 18) check("t4 dir second", {30'd0, mv.move_dir}, 32'd2);
            if (k == 15) check("t4 stable both", {28'd0, mv.sw_stable}, 32'h5);
            if (k == 16) check("t4 stable left", {28'd0, mv.sw_stable}, 32'h4);
            if (k == 10) set_sw(4'b0100);
        end

        // Test 5: SW3 held into REPEAT, RST pulsed; next strobe 7 cycles after release.
        do_reset();
        set_sw(4'b0100);
        for (int k = 1; k <= 19; k++) begin
            tick();
            exp_v = (k == 7) || (k == 17);
            check($sformatf("t5 valid c%0d", k), {31'd0, mv.move_valid}, {31'd0, exp_v});
        end
        RST = 1'b1;
        tick();
        check("t5 reset outputs", {25'd0, mv.move_valid, mv.move_dir, mv.sw_stable}, 32'd0);
        RST = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("t5 post valid c%0d", k), {31'd0, mv.move_valid}, {31'd0, (k == 7)});
        end
        check("t5 post dir", {30'd0, mv.move_dir}, 32'd2);

        // Test 6: bouncing random presses; strobes never back-to-back and
        // always name a button that was debounced-pressed the cycle before.
        do_reset();
        tgt         = 4'b0000;
        prev_valid  = 1'b0;
        prev_stable = 4'b0000;
        for (int k = 0; k < 20000; k++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 39) == 0) tgt[b] = ~tgt[b];
                raw[b] = tgt[b] ^ ($urandom_range(0, 7) == 0);
            end
            set_sw(raw);
            tick();
            check("t6 no double strobe", {31'd0, (mv.move_valid && prev_valid)}, 32'd0);
            if (mv.move_valid)
                check("t6 dir pressed", {31'd0, prev_stable[mv.move_dir]}, 32'd1);
            prev_valid  = mv.move_valid;
            prev_stable = mv.sw_stable;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
